// File: rtl/soda_pkg.sv
// Shared constants and types for the soda vending controller and its TAP.
package soda_pkg;

  localparam int unsigned CREDIT_W     = 7;
  localparam int unsigned COIN_NICKEL  = 5;
  localparam int unsigned COIN_DIME    = 10;
  localparam int unsigned COIN_QUARTER = 25;

  localparam int unsigned IDCODE_W = 32;
  localparam int unsigned STATUS_W = 8;

  localparam logic [3:0] IR_IDCODE  = 4'b0001;
  localparam logic [3:0] IR_STATUS  = 4'b0010;
  localparam logic [3:0] IR_BYPASS  = 4'b1111;
  localparam logic [3:0] IR_CAPTURE = 4'b0001;

  typedef enum logic [3:0] {
    TAP_RESET, TAP_IDLE,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
  } tap_state_t;

  typedef enum logic [1:0] {DR_BYPASS, DR_IDCODE, DR_STATUS} dr_sel_t;

endpackage

// File: rtl/soda_machine_if.sv
// Coin inputs and vending outputs of the soda machine.
interface soda_machine_if;
  logic n2;
  logic d2;
  logic q2;
  logic n_out;
  logic d_out;
  logic dispense;

  modport master (output n2, d2, q2, input n_out, d_out, dispense);
  modport slave  (input n2, d2, q2, output n_out, d_out, dispense);
endinterface

// File: rtl/soda_tap.sv
// JTAG TAP: 16-state controller, IR, IDCODE/STATUS/BYPASS data registers.
module soda_tap
  import soda_pkg::*;
#(
  parameter int unsigned IR_W       = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h0100_5A17
) (
  input  logic                clk,
  input  logic                trst_n,
  input  logic                tms,
  input  logic                tdi,
  input  logic [STATUS_W-1:0] status,
  output logic                tdo
);

  tap_state_t          state, state_nxt;
  logic [IR_W-1:0]     ir, ir_sh;
  logic [IDCODE_W-1:0] dr_sh;
  dr_sel_t             dr_sel_c;

  // TAP state register
  always_ff @(posedge clk or negedge trst_n) begin
    if (!trst_n) state <= TAP_RESET;
    else         state <= state_nxt;
  end

  // TAP next-state decode from tms
  always_comb begin
    state_nxt = state;
    case (state)
      TAP_RESET: state_nxt = tms ? TAP_RESET : TAP_IDLE;
      TAP_IDLE:  state_nxt = tms ? SEL_DR    : TAP_IDLE;
      SEL_DR:    state_nxt = tms ? SEL_IR    : CAP_DR;
      CAP_DR:    state_nxt = tms ? EX1_DR    : SH_DR;
      SH_DR:     state_nxt = tms ? EX1_DR    : SH_DR;
      EX1_DR:    state_nxt = tms ? UPD_DR    : PAUSE_DR;
      PAUSE_DR:  state_nxt = tms ? EX2_DR    : PAUSE_DR;
      EX2_DR:    state_nxt = tms ? UPD_DR    : SH_DR;
      UPD_DR:    state_nxt = tms ? SEL_DR    : TAP_IDLE;
      SEL_IR:    state_nxt = tms ? TAP_RESET : CAP_IR;
      CAP_IR:    state_nxt = tms ? EX1_IR    : SH_IR;
      SH_IR:     state_nxt = tms ? EX1_IR    : SH_IR;
      EX1_IR:    state_nxt = tms ? UPD_IR    : PAUSE_IR;
      PAUSE_IR:  state_nxt = tms ? EX2_IR    : PAUSE_IR;
      EX2_IR:    state_nxt = tms ? UPD_IR    : SH_IR;
      UPD_IR:    state_nxt = tms ? SEL_DR    : TAP_IDLE;
      default:   state_nxt = TAP_RESET;
    endcase
  end

  // Instruction decode; unknown codes fall back to bypass
  always_comb begin
    dr_sel_c = DR_BYPASS;
    if (ir == IR_W'(IR_IDCODE))      dr_sel_c = DR_IDCODE;
    else if (ir == IR_W'(IR_STATUS)) dr_sel_c = DR_STATUS;
    else if (ir == IR_W'(IR_BYPASS)) dr_sel_c = DR_BYPASS;
  end

  // Instruction register: capture, shift, update; IDCODE while in reset
  always_ff @(posedge clk or negedge trst_n) begin
    if (!trst_n) begin
      ir    <= IR_W'(IR_IDCODE);
      ir_sh <= '0;
    end else begin
      case (state)
        TAP_RESET: ir    <= IR_W'(IR_IDCODE);
        CAP_IR:    ir_sh <= IR_W'(IR_CAPTURE);
        SH_IR:     ir_sh <= {tdi, ir_sh[IR_W-1:1]};
        UPD_IR:    ir    <= ir_sh;
        default:   ;
      endcase
    end
  end

  // Data shift register; length follows the selected DR, tdi enters its MSB
  always_ff @(posedge clk or negedge trst_n) begin
    if (!trst_n) begin
      dr_sh <= '0;
    end else if (state == CAP_DR) begin
      case (dr_sel_c)
        DR_IDCODE: dr_sh <= IDCODE_VAL;
        DR_STATUS: dr_sh <= IDCODE_W'(status);
        default:   dr_sh <= '0;
      endcase
    end else if (state == SH_DR) begin
      case (dr_sel_c)
        DR_IDCODE: dr_sh <= {tdi, dr_sh[IDCODE_W-1:1]};
        DR_STATUS: dr_sh <= IDCODE_W'({tdi, dr_sh[STATUS_W-1:1]});
        default:   dr_sh <= IDCODE_W'(tdi);
      endcase
    end
  end

  // Serial out is live only while shifting
  always_comb begin
    tdo = 1'b0;
    if (state == SH_DR)      tdo = dr_sh[0];
    else if (state == SH_IR) tdo = ir_sh[0];
  end

endmodule

// File: rtl/soda_machine.sv
// Coin-operated soda vending controller with JTAG identification/status TAP.
module soda_machine
  import soda_pkg::*;
#(
  parameter int unsigned PRICE      = 35,
  parameter logic [31:0] IDCODE_VAL = 32'h0100_5A17,
  parameter int unsigned IR_W       = 4
) (
  input  logic           clk,
  input  logic           rst,
  soda_machine_if.slave  bus,
  input  logic           tdi,
  output logic           tdo,
  input  logic           tck,
  input  logic           tms,
  input  logic           trst_n
);

  logic [CREDIT_W-1:0] credit, change;
  logic [CREDIT_W-1:0] coin_val_c, sum_c;
  logic                dispense_q, n_out_q, d_out_q;
  logic                busy_c;
  logic [STATUS_W-1:0] status_c;
  logic                tck_unused;

  // tck is the same net as clk at integration; nothing samples it here
  assign tck_unused = tck;

  // Single accepted coin per cycle, quarter over dime over nickel
  always_comb begin
    coin_val_c = '0;
    if (!bus.q2)      coin_val_c = CREDIT_W'(COIN_QUARTER);
    else if (!bus.d2) coin_val_c = CREDIT_W'(COIN_DIME);
    else if (!bus.n2) coin_val_c = CREDIT_W'(COIN_NICKEL);
  end

  assign sum_c  = credit + coin_val_c;
  assign busy_c = (change != '0);

  // Credit accumulation, dispense and one-coin-per-cycle change return
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit     <= '0;
      change     <= '0;
      dispense_q <= 1'b0;
      n_out_q    <= 1'b0;
      d_out_q    <= 1'b0;
    end else begin
      dispense_q <= 1'b0;
      n_out_q    <= 1'b0;
      d_out_q    <= 1'b0;
      if (busy_c) begin
        if (change >= CREDIT_W'(COIN_DIME)) begin
          d_out_q <= 1'b1;
          change  <= change - CREDIT_W'(COIN_DIME);
        end else begin
          // change is always a multiple of 5, so the remainder is one nickel
          n_out_q <= 1'b1;
          change  <= '0;
        end
      end else if (coin_val_c != '0) begin
        if (sum_c >= CREDIT_W'(PRICE)) begin
          dispense_q <= 1'b1;
          change     <= sum_c - CREDIT_W'(PRICE);
          credit     <= '0;
        end else begin
          credit <= sum_c;
        end
      end
    end
  end

  assign bus.dispense = dispense_q;
  assign bus.n_out    = n_out_q;
  assign bus.d_out    = d_out_q;

  // Status snapshot in nickel units for the STATUS scan register
  assign status_c = {busy_c, 3'(credit / CREDIT_W'(5)), 3'(change / CREDIT_W'(5)), 1'b0};

  soda_tap #(
    .IR_W       (IR_W),
    .IDCODE_VAL (IDCODE_VAL)
  ) u_tap (
    .clk    (clk),
    .trst_n (trst_n),
    .tms    (tms),
    .tdi    (tdi),
    .status (status_c),
    .tdo    (tdo)
  );

endmodule

// File: tb/tb_soda_machine.sv
// Scoreboard bench: coin/JTAG stimulus pushes expectations, a monitor checks them.
module tb_soda_machine;

  localparam int unsigned PRICE      = 35;
  localparam logic [31:0] IDCODE_VAL = 32'h0100_5A17;
  localparam int unsigned IR_W       = 4;

  typedef struct { logic [2:0] outs; int cyc; } vev_t;
  typedef struct { logic val; int cyc; } jev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic trst_n = 1'b0;
  logic tms = 1'b1;
  logic tdi = 1'b0;
  logic tck;
  logic tdo;

  soda_machine_if bus_if ();

  assign tck = clk;

  soda_machine #(
    .PRICE      (PRICE),
    .IDCODE_VAL (IDCODE_VAL),
    .IR_W       (IR_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus_if),
    .tdi    (tdi),
    .tdo    (tdo),
    .tck    (tck),
    .tms    (tms),
    .trst_n (trst_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  vev_t vq[$];
  jev_t jq[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   done = 1'b0;

  // Reference model state: credit in cents and last posedge of change payout
  int m_credit = 0;
  int busy_until = 0;

  // One coin-input cycle; model predicts dispense and change events by edge number
  task automatic coin(input logic n, input logic d, input logic q);
    int v, p, chg, t;
    @(negedge clk);
    bus_if.n2 = n;
    bus_if.d2 = d;
    bus_if.q2 = q;
    p = cyc + 1;
    v = !q ? 25 : (!d ? 10 : (!n ? 5 : 0));
    if (v != 0 && p > busy_until) begin
      m_credit = m_credit + v;
      if (m_credit >= PRICE) begin
        chg = m_credit - PRICE;
        m_credit = 0;
        vq.push_back('{3'b100, p});
        t = p;
        while (chg >= 10) begin
          t++;
          vq.push_back('{3'b001, t});
          chg = chg - 10;
        end
        if (chg == 5) begin
          t++;
          vq.push_back('{3'b010, t});
        end
        busy_until = t;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) coin(1'b1, 1'b1, 1'b1);
  endtask

  // One TAP clock: drive tms/tdi and expect tdo after the resulting edge
  task automatic jstep(input logic tms_v, input logic tdi_v, input logic exp_v);
    @(negedge clk);
    tms = tms_v;
    tdi = tdi_v;
    jq.push_back('{exp_v, cyc + 1});
  endtask

  task automatic jtrst();
    @(negedge clk);
    trst_n = 1'b0;
    tms = 1'b1;
    tdi = 1'b0;
    jq.push_back('{1'b0, cyc + 1});
    @(negedge clk);
    trst_n = 1'b1;
    jq.push_back('{1'b0, cyc + 1});
  endtask

  // From Shift state: shift nbits (last one exits), then Update and back to Idle
  task automatic scan(input int len, input int nbits, input logic [31:0] cap, input logic [31:0] din);
    logic [31:0] r;
    logic e;
    logic last;
    r = cap;
    for (int i = 0; i < nbits; i++) begin
      last = (i == nbits - 1);
      r = r >> 1;
      r[len-1] = din[i];
      e = last ? 1'b0 : r[0];
      jstep(last, din[i], e);
    end
    jstep(1'b1, 1'b0, 1'b0);
    jstep(1'b0, 1'b0, 1'b0);
  endtask

  task automatic enter_dr(input logic cap0);
    jstep(1'b1, 1'b0, 1'b0);
    jstep(1'b0, 1'b0, 1'b0);
    jstep(1'b0, 1'b0, cap0);
  endtask

  task automatic load_ir(input logic [3:0] code);
    jstep(1'b1, 1'b0, 1'b0);
    jstep(1'b1, 1'b0, 1'b0);
    jstep(1'b0, 1'b0, 1'b0);
    jstep(1'b0, 1'b0, 1'b1);
    scan(IR_W, IR_W, 32'(4'b0001), 32'(code));
  endtask

  task automatic read_dr(input int len, input int nbits, input logic [31:0] cap, input logic [31:0] din);
    enter_dr(cap[0]);
    scan(len, nbits, cap, din);
  endtask

  // Expected DR length and capture value for an instruction, machine idle
  task automatic dr_expect(input logic [3:0] code, output int len, output logic [31:0] cap);
    if (code == 4'b0001) begin
      len = 32;
      cap = IDCODE_VAL;
    end else if (code == 4'b0010) begin
      len = 8;
      cap = 32'({1'b0, 3'(m_credit / 5), 3'b000, 1'b0});
    end else begin
      len = 1;
      cap = 32'd0;
    end
  endtask

  logic [2:0] m_obs, m_exp;
  jev_t       m_je;

  // Monitor: every cycle compares vend outputs; drains due tdo expectations
  always @(negedge clk) begin
    m_obs = {bus_if.dispense, bus_if.n_out, bus_if.d_out};
    m_exp = 3'b000;
    if (vq.size() > 0 && vq[0].cyc <= cyc) begin
      if (vq[0].cyc == cyc) begin
        m_exp = vq[0].outs;
      end else begin
        miscompares++;
        $display("FAIL vend_missed: event %b due cycle %0d not seen by cycle %0d", vq[0].outs, vq[0].cyc, cyc);
      end
      void'(vq.pop_front());
    end
    vectors++;
    if (m_obs !== m_exp) begin
      miscompares++;
      $display("FAIL vend_out cycle %0d: {dispense,n_out,d_out} got %b expected %b", cyc, m_obs, m_exp);
    end
    while (jq.size() > 0 && jq[0].cyc <= cyc) begin
      m_je = jq.pop_front();
      vectors++;
      if (m_je.cyc != cyc || tdo !== m_je.val) begin
        miscompares++;
        $display("FAIL tdo cycle %0d (due %0d): got %b expected %b", cyc, m_je.cyc, tdo, m_je.val);
      end
    end
    if (done) begin
      vectors += 2;
      if (vq.size() != 0) begin
        miscompares++;
        $display("FAIL vend_leftover: %0d expected events never seen, wanted 0", vq.size());
      end
      if (jq.size() != 0) begin
        miscompares++;
        $display("FAIL tdo_leftover: %0d expectations unchecked, wanted 0", jq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    logic [31:0] cap;
    logic [3:0] code;
    bus_if.n2 = 1'b1;
    bus_if.d2 = 1'b1;
    bus_if.q2 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    trst_n = 1'b1;

    // IDCODE is the default instruction after TAP reset
    jtrst();
    repeat (5) jstep(1'b1, 1'b0, 1'b0);
    jstep(1'b0, 1'b0, 1'b0);
    read_dr(32, 32, IDCODE_VAL, 32'd0);

    // Seven nickels reach exactly the price
    repeat (7) coin(1'b0, 1'b1, 1'b1);
    idle(4);

    // 30 + 25 = 55 -> two dimes back
    repeat (3) coin(1'b1, 1'b0, 1'b1);
    coin(1'b1, 1'b1, 1'b0);
    idle(5);

    // Quarter then dime+nickel together: dime wins, exact price
    coin(1'b1, 1'b1, 1'b0);
    coin(1'b0, 1'b0, 1'b1);
    idle(4);

    // BYPASS echoes tdi one cycle late, 0 first
    load_ir(4'b1111);
    read_dr(1, 5, 32'd0, 32'b01101);

    // Credit 15 read back through STATUS
    coin(1'b1, 1'b0, 1'b1);
    coin(1'b0, 1'b1, 1'b1);
    idle(3);
    load_ir(4'b0010);
    dr_expect(4'b0010, len, cap);
    read_dr(len, len, cap, $urandom);

    // TAP reset mid-shift aborts the scan and restores IDCODE; credit untouched
    load_ir(4'b0010);
    enter_dr(cap[0]);
    for (int i = 1; i <= 3; i++) jstep(1'b0, 1'b1, cap[i]);
    jtrst();
    jstep(1'b0, 1'b0, 1'b0);
    read_dr(32, 32, IDCODE_VAL, $urandom);
    load_ir(4'b0010);
    dr_expect(4'b0010, len, cap);
    read_dr(len, len, cap, 32'd0);

    // Random coin traffic
    for (int i = 0; i < 300; i++)
      coin(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
    idle(5);

    // Random instructions interleaved with coin bursts
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 6; i++)
        coin(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0));
      idle(5);
      case ($urandom_range(0, 3))
        0:       code = 4'b0001;
        1:       code = 4'b0010;
        2:       code = 4'b1111;
        default: code = 4'($urandom);
      endcase
      load_ir(code);
      dr_expect(code, len, cap);
      read_dr(len, len, cap, $urandom);
    end

    idle(4);
    done = 1'b1;
  end

endmodule
